// File: rtl/clk_mon_pkg.sv
// Shared types and default sizing for the clock ratio monitor.
package clk_mon_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    MEASURE = 2'd2
  } mon_state_e;

  localparam int DEF_CNT_W    = 16;
  localparam int DEF_LOCK_CNT = 4;
  localparam int DEF_TIMEOUT  = 1024;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer followed by a rising-edge detector.
// rise is a one-cycle pulse; it is consumed three clk_a edges after din rises.
module sync_edge_det (
  input  logic clk_a,
  input  logic rst,
  input  logic din,
  output logic rise
);
  logic s1_q, s2_q, prev_q;

  // Synchronize din into clk_a and keep one extra stage for edge detection
  always_ff @(posedge clk_a) begin
    if (rst) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      s1_q   <= din;
      s2_q   <= s1_q;
      prev_q <= s2_q;
    end
  end

  assign rise = s2_q & ~prev_q;

endmodule

// File: rtl/clk_ratio_monitor.sv
// Measures the period of mon_clk in clk_a cycles, checks it against
// exp_period +/- tolerance, tracks lock and raises sticky error flags.
module clk_ratio_monitor
  import clk_mon_pkg::*;
#(
  parameter int CNT_W    = DEF_CNT_W,
  parameter int LOCK_CNT = DEF_LOCK_CNT,
  parameter int TIMEOUT  = DEF_TIMEOUT
) (
  input  logic             clk_a,
  input  logic             rst,
  input  logic             enable,
  input  logic             mon_clk,
  input  logic [CNT_W-1:0] exp_period,
  input  logic [CNT_W-1:0] tolerance,
  input  logic             clr_err,
  output logic [CNT_W-1:0] period_out,
  output logic             period_valid,
  output logic             locked,
  output logic             err_fast,
  output logic             err_slow,
  output logic             err_stuck
);
  localparam int                CONS_W = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0]  TMO    = CNT_W'(TIMEOUT);
  localparam logic [CONS_W-1:0] LOCK_N = CONS_W'(LOCK_CNT);

  mon_state_e          state_q, state_d;
  logic                rise;
  logic [CNT_W-1:0]    cnt_q, cnt_inc;
  logic [CONS_W-1:0]   consec_q, consec_nxt;
  logic                tmo_hit;
  logic [CNT_W:0]      period_w, lo_bound, hi_bound;
  logic                too_fast, too_slow;
  logic                meas_done, acq_tmo, meas_tmo;
  logic                set_fast, set_slow, set_stuck;

  sync_edge_det u_sync (
    .clk_a (clk_a),
    .rst   (rst),
    .din   (mon_clk),
    .rise  (rise)
  );

  // cnt never reaches TIMEOUT: the cycle it would is treated as a timeout,
  // so the longest reportable period is exactly TIMEOUT.
  assign cnt_inc    = cnt_q + CNT_W'(1);
  assign tmo_hit    = (cnt_inc == TMO);
  assign consec_nxt = (consec_q == LOCK_N) ? consec_q : consec_q + CONS_W'(1);

  // Bounds are one bit wider so exp+tol cannot wrap; lower bound floors at 0.
  assign period_w = {1'b0, cnt_q} + (CNT_W+1)'(1);
  assign lo_bound = (exp_period > tolerance) ? {1'b0, exp_period - tolerance} : '0;
  assign hi_bound = {1'b0, exp_period} + {1'b0, tolerance};
  assign too_fast = period_w < lo_bound;
  assign too_slow = period_w > hi_bound;

  // State register
  always_ff @(posedge clk_a) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state: enable low always returns to IDLE
  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    state_d = ACQUIRE;
        ACQUIRE: if (rise) state_d = MEASURE;
        MEASURE: if (!rise && tmo_hit) state_d = ACQUIRE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Output decode: measurement completion, timeouts and flag set strobes
  always_comb begin
    meas_done = enable && (state_q == MEASURE) && rise;
    acq_tmo   = enable && (state_q == ACQUIRE) && !rise && tmo_hit;
    meas_tmo  = enable && (state_q == MEASURE) && !rise && tmo_hit;
    set_fast  = meas_done && too_fast;
    set_slow  = meas_done && too_slow;
    set_stuck = acq_tmo || meas_tmo;
  end

  // Datapath: period counter, lock tracking, result and sticky flags
  always_ff @(posedge clk_a) begin
    if (rst) begin
      cnt_q        <= '0;
      consec_q     <= '0;
      period_out   <= '0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
      err_fast     <= 1'b0;
      err_slow     <= 1'b0;
      err_stuck    <= 1'b0;
    end else begin
      period_valid <= meas_done;
      if (meas_done) period_out <= period_w[CNT_W-1:0];

      if (!enable || state_q == IDLE || rise || tmo_hit) cnt_q <= '0;
      else                                               cnt_q <= cnt_inc;

      if (!enable || state_q == IDLE || meas_tmo) begin
        consec_q <= '0;
        locked   <= 1'b0;
      end else if (meas_done) begin
        if (too_fast || too_slow) begin
          consec_q <= '0;
          locked   <= 1'b0;
        end else begin
          consec_q <= consec_nxt;
          locked   <= (consec_nxt == LOCK_N);
        end
      end

      // A new error in the same cycle as clr_err wins
      err_fast  <= set_fast  | (err_fast  & ~clr_err);
      err_slow  <= set_slow  | (err_slow  & ~clr_err);
      err_stuck <= set_stuck | (err_stuck & ~clr_err);
    end
  end

endmodule
